// File: rtl/pipeline_hazard_controller_if.sv
// Bundle between the pipeline registers and pipeline_hazard_controller.
//   master : pipeline side. It drives the hazard, branch and memory status
//            signals and receives the register enables, flushes and status.
//   slave  : the controller itself.
//   CNT_W  : width of the StallCnt/FlushCnt/WaitCnt perf counters.
interface pipeline_hazard_controller_if #(
  parameter int CNT_W = 16
);
  logic             ID_EXE_MemRead;
  logic [4:0]       ID_EXE_Rt;
  logic [4:0]       IF_ID_Rs;
  logic [4:0]       IF_ID_Rt;
  logic             IF_ID_UsesRt;
  logic             EXE_MEM_BranchEqual;
  logic             EXE_MEM_BranchnotEqual;
  logic             EXE_MEM_Zero;
  logic             EXE_MEM_MemRead;
  logic             EXE_MEM_MemWrite;
  logic             DMemReady;

  logic             PC_Write;
  logic             IF_ID_Write;
  logic             ID_EXE_Write;
  logic             EXE_MEM_Write;
  logic             IF_ID_Flush;
  logic             ID_EXE_Flush;
  logic             EXE_MEM_Flush;
  logic             PCSrc;
  logic             Trap;
  logic [1:0]       State;
  logic [CNT_W-1:0] StallCnt;
  logic [CNT_W-1:0] FlushCnt;
  logic [CNT_W-1:0] WaitCnt;

  modport master (
    output ID_EXE_MemRead, ID_EXE_Rt, IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt,
           EXE_MEM_BranchEqual, EXE_MEM_BranchnotEqual, EXE_MEM_Zero,
           EXE_MEM_MemRead, EXE_MEM_MemWrite, DMemReady,
    input  PC_Write, IF_ID_Write, ID_EXE_Write, EXE_MEM_Write,
           IF_ID_Flush, ID_EXE_Flush, EXE_MEM_Flush, PCSrc, Trap, State,
           StallCnt, FlushCnt, WaitCnt
  );

  modport slave (
    input  ID_EXE_MemRead, ID_EXE_Rt, IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt,
           EXE_MEM_BranchEqual, EXE_MEM_BranchnotEqual, EXE_MEM_Zero,
           EXE_MEM_MemRead, EXE_MEM_MemWrite, DMemReady,
    output PC_Write, IF_ID_Write, ID_EXE_Write, EXE_MEM_Write,
           IF_ID_Flush, ID_EXE_Flush, EXE_MEM_Flush, PCSrc, Trap, State,
           StallCnt, FlushCnt, WaitCnt
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
//   Sequences the PC and the IF/ID, ID/EXE and EXE/MEM pipeline registers.
//   It produces write enables and flushes from three sources: load-use
//   hazards in ID, taken branches in MEM, and the data-memory ready
//   handshake. A data-memory wait that runs too long traps, and the trap
//   is cleared only by reset.
// Ports
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset. While it is low the outputs are
//           forced to their reset values.
//   bus   : pipeline_hazard_controller_if.slave. Hazard, branch and memory
//           status come in; register enables, flushes, PCSrc, Trap, State
//           and the perf counters go out.
// Parameters
//   LOAD_STALL_CYCLES (1..7) : bubbles inserted per load-use hazard
//   MEM_TIMEOUT              : wait cycles before a trap, 0 disables it
//   CNT_W                    : perf counter width
// Build option
//   HAZ_PERF_CNT_EN : when defined, adds saturating stall/flush/wait counters.
//                     When undefined, StallCnt, FlushCnt and WaitCnt read 0.
//
// state    | meaning
// RUN      | normal issue; detects memwait, then taken branch, then load-use
// LD_STALL | extra load-use bubbles; stall_left counts the bubbles left
// MEM_WAIT | pipeline frozen until DMemReady; returns to ret
// TRAP     | memory timeout; frozen until reset
module pipeline_hazard_controller #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT       = 64,
  parameter int CNT_W             = 16
) (
  input logic clk,
  input logic rst_n,
  pipeline_hazard_controller_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    TRAP     = 2'd3
  } state_t;

  // The wait timer is a down-counter. It is loaded with MEM_TIMEOUT-1 when
  // the pipeline enters MEM_WAIT, and a trap is taken when it reaches zero.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD =
    (MEM_TIMEOUT > 1) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;
  localparam logic [2:0] STALL_LOAD = 3'(LOAD_STALL_CYCLES - 1);

  state_t            state, state_nxt, ret, ret_nxt;
  logic [2:0]        stall_left, stall_left_nxt;
  logic [WAIT_W-1:0] wait_left, wait_left_nxt;
  logic              memwait, taken, luh;
  logic              pc_write, if_id_write, id_exe_write, exe_mem_write;
  logic              if_id_flush, id_exe_flush, exe_mem_flush, pc_src;

  assign memwait = (bus.EXE_MEM_MemRead | bus.EXE_MEM_MemWrite) & ~bus.DMemReady;
  assign taken   = (bus.EXE_MEM_BranchEqual & bus.EXE_MEM_Zero) |
                   (bus.EXE_MEM_BranchnotEqual & ~bus.EXE_MEM_Zero);
  assign luh     = bus.ID_EXE_MemRead && (bus.ID_EXE_Rt != 5'd0) &&
                   ((bus.ID_EXE_Rt == bus.IF_ID_Rs) ||
                    (bus.IF_ID_UsesRt && (bus.ID_EXE_Rt == bus.IF_ID_Rt)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      ret        <= RUN;
      stall_left <= '0;
      wait_left  <= '0;
    end else begin
      state      <= state_nxt;
      ret        <= ret_nxt;
      stall_left <= stall_left_nxt;
      wait_left  <= wait_left_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    ret_nxt        = ret;
    stall_left_nxt = stall_left;
    wait_left_nxt  = wait_left;
    pc_write       = 1'b1;
    if_id_write    = 1'b1;
    id_exe_write   = 1'b1;
    exe_mem_write  = 1'b1;
    if_id_flush    = 1'b0;
    id_exe_flush   = 1'b0;
    exe_mem_flush  = 1'b0;
    pc_src         = 1'b0;

    unique case (state)
      RUN: begin
        if (memwait) begin
          {pc_write, if_id_write, id_exe_write, exe_mem_write} = 4'b0000;
          state_nxt     = MEM_WAIT;
          ret_nxt       = RUN;
          wait_left_nxt = WAIT_LOAD;
        end else if (taken) begin
          pc_src        = 1'b1;
          if_id_flush   = 1'b1;
          id_exe_flush  = 1'b1;
          exe_mem_flush = 1'b1;
        end else if (luh) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_exe_flush = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            state_nxt      = LD_STALL;
            stall_left_nxt = STALL_LOAD;
          end
        end
      end
      LD_STALL: begin
        if (memwait) begin
          {pc_write, if_id_write, id_exe_write, exe_mem_write} = 4'b0000;
          state_nxt     = MEM_WAIT;
          ret_nxt       = LD_STALL;
          wait_left_nxt = WAIT_LOAD;
        end else begin
          pc_write       = 1'b0;
          if_id_write    = 1'b0;
          id_exe_flush   = 1'b1;
          stall_left_nxt = stall_left - 3'd1;
          if (stall_left == 3'd1) state_nxt = RUN;
        end
      end
      MEM_WAIT: begin
        if (bus.DMemReady) begin
          state_nxt = ret;
        end else begin
          {pc_write, if_id_write, id_exe_write, exe_mem_write} = 4'b0000;
          if ((MEM_TIMEOUT != 0) && (wait_left == '0)) state_nxt = TRAP;
          else if (wait_left != '0) wait_left_nxt = wait_left - WAIT_W'(1);
        end
      end
      TRAP: begin
        {pc_write, if_id_write, id_exe_write, exe_mem_write} = 4'b0000;
      end
    endcase

    // Reset must act on the outputs at once, before any clock edge.
    if (!rst_n) begin
      {pc_write, if_id_write, id_exe_write, exe_mem_write} = 4'b0000;
      {if_id_flush, id_exe_flush, exe_mem_flush}           = 3'b111;
      pc_src = 1'b0;
    end
  end

  assign bus.PC_Write      = pc_write;
  assign bus.IF_ID_Write   = if_id_write;
  assign bus.ID_EXE_Write  = id_exe_write;
  assign bus.EXE_MEM_Write = exe_mem_write;
  assign bus.IF_ID_Flush   = if_id_flush;
  assign bus.ID_EXE_Flush  = id_exe_flush;
  assign bus.EXE_MEM_Flush = exe_mem_flush;
  assign bus.PCSrc         = pc_src;
  assign bus.Trap          = rst_n && (state == TRAP);
  assign bus.State         = state;

`ifdef HAZ_PERF_CNT_EN
  logic             ev_bubble, ev_taken, ev_wait;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, wait_cnt;

  assign ev_bubble = ((state == RUN) && !memwait && !taken && luh) ||
                     ((state == LD_STALL) && !memwait);
  assign ev_taken  = (state == RUN) && !memwait && taken;
  assign ev_wait   = (((state == RUN) || (state == LD_STALL)) && memwait) ||
                     ((state == MEM_WAIT) && !bus.DMemReady);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      if (ev_bubble && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (ev_taken  && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
      if (ev_wait   && (wait_cnt  != '1)) wait_cnt  <= wait_cnt  + CNT_W'(1);
    end
  end

  assign bus.StallCnt = stall_cnt;
  assign bus.FlushCnt = flush_cnt;
  assign bus.WaitCnt  = wait_cnt;
`else
  assign bus.StallCnt = '0;
  assign bus.FlushCnt = '0;
  assign bus.WaitCnt  = '0;
`endif

endmodule
